// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter family.
package wb_arb_pkg;

   localparam int MAX_MASTERS = 8;
   localparam int PTR_MAX_W   = 3;
   localparam int BYTE_W      = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   function automatic int sel_width(input int data_w);
      return data_w / BYTE_W;
   endfunction

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // One-hot grant for the first requester at or after ptr, wrapping modulo n.
   function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                       input logic [PTR_MAX_W-1:0]   ptr,
                                                       input int                     n);
      logic [MAX_MASTERS-1:0] gnt;
      logic [PTR_MAX_W-1:0]   idx;
      gnt = '0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         idx = PTR_MAX_W'((int'(ptr) + i) % n);
         if (i < n && gnt == '0 && req[idx]) gnt[idx] = 1'b1;
      end
      return gnt;
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin priority encoder: request vector + start pointer -> one-hot grant.
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int N = 2,
   localparam int PW = ptr_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   assign gnt_o = N'(rr_pick(MAX_MASTERS'(req_i), PTR_MAX_W'(ptr_i), N));

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave pipelined Wishbone round-robin arbiter; grant held for the whole cyc.
// Define WB_RR_ARBITER_WATCHDOG_EN to add the bus watchdog and the sticky timeout_o flag.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32
`ifdef WB_RR_ARBITER_WATCHDOG_EN
   ,
   parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [N_MASTERS-1:0]                   m_cyc_i,
   input  logic [N_MASTERS-1:0]                   m_stb_i,
   input  logic [N_MASTERS-1:0]                   m_we_i,
   input  logic [N_MASTERS*ADDR_W-1:0]            m_adr_i,
   input  logic [N_MASTERS*sel_width(DATA_W)-1:0] m_sel_i,
   input  logic [N_MASTERS*DATA_W-1:0]            m_dat_i,
   output logic [N_MASTERS-1:0]                   m_ack_o,
   output logic [N_MASTERS-1:0]                   m_err_o,
   output logic [N_MASTERS-1:0]                   m_stall_o,
   output logic [DATA_W-1:0]                      m_dat_o,
   output logic                                   s_cyc_o,
   output logic                                   s_stb_o,
   output logic                                   s_we_o,
   output logic [ADDR_W-1:0]                      s_adr_o,
   output logic [sel_width(DATA_W)-1:0]           s_sel_o,
   output logic [DATA_W-1:0]                      s_dat_o,
   input  logic                                   s_ack_i,
   input  logic                                   s_err_i,
   input  logic                                   s_stall_i,
   input  logic [DATA_W-1:0]                      s_dat_i,
   output logic [N_MASTERS-1:0]                   grant_o
`ifdef WB_RR_ARBITER_WATCHDOG_EN
   ,
   output logic                                   timeout_o
`endif
);

   localparam int SEL_W = sel_width(DATA_W);
   localparam int PTR_W = ptr_width(N_MASTERS);

   arb_state_e           state_q, state_d;
   logic [N_MASTERS-1:0] grant_q, grant_d, pick;
   logic [PTR_W-1:0]     ptr_q, ptr_d, next_ptr;
   logic                 g_cyc, g_stb, g_we, release_bus;

`ifdef WB_RR_ARBITER_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q, timeout_d, wd_fire;
   assign timeout_o = timeout_q;
`endif

   // ptr_q holds where the next search starts, so reset value 0 means master 0 is tried first.
   wb_rr_pick #(.N(N_MASTERS)) u_pick (
      .req_i (m_cyc_i),
      .ptr_i (ptr_q),
      .gnt_o (pick)
   );

   assign m_dat_o = s_dat_i;
   assign grant_o = grant_q;

   // One-hot AND-OR mux of the granted master's request signals.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path can infer a latch.
      g_cyc    = 1'b0;
      g_stb    = 1'b0;
      g_we     = 1'b0;
      s_adr_o  = '0;
      s_sel_o  = '0;
      s_dat_o  = '0;
      next_ptr = ptr_q;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (grant_q[i]) begin
            g_cyc    = m_cyc_i[i];
            g_stb    = m_stb_i[i];
            g_we     = m_we_i[i];
            s_adr_o  = m_adr_i[i*ADDR_W +: ADDR_W];
            s_sel_o  = m_sel_i[i*SEL_W +: SEL_W];
            s_dat_o  = m_dat_i[i*DATA_W +: DATA_W];
            next_ptr = PTR_W'((i + 1) % N_MASTERS);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      s_cyc_o     = 1'b0;
      s_stb_o     = 1'b0;
      s_we_o      = 1'b0;
      m_ack_o     = '0;
      m_err_o     = '0;
      m_stall_o   = '1;
      release_bus = 1'b0;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
      wd_d        = wd_q;
      timeout_d   = timeout_q;
      wd_fire     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|m_cyc_i) begin
               grant_d = pick;
               state_d = BUSY;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
               wd_d    = '0;
`endif
            end
         end
         BUSY: begin
            s_cyc_o     = g_cyc;
            s_stb_o     = g_stb;
            s_we_o      = g_we;
            m_ack_o     = grant_q & {N_MASTERS{s_ack_i}};
            m_err_o     = grant_q & {N_MASTERS{s_err_i}};
            m_stall_o   = ~grant_q | {N_MASTERS{s_stall_i}};
            release_bus = ~g_cyc;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
            if (wd_q == WD_W'(TIMEOUT_CYC)) begin
               wd_fire   = 1'b1;
               s_cyc_o   = 1'b0;
               s_stb_o   = 1'b0;
               m_ack_o   = '0;
               m_err_o   = grant_q;
               timeout_d = 1'b1;
            end else if (s_ack_i || s_err_i) begin
               wd_d = '0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
            release_bus = release_bus | wd_fire;
`endif
            if (release_bus) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = next_ptr;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
         wd_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
`endif
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus a read-data/ack scoreboard.
module tb_wb_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SW = DW / 8;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
   localparam int TO = 16;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic [N-1:0]    m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
   logic [N*AW-1:0] m_adr_i = '0;
   logic [N*SW-1:0] m_sel_i = '0;
   logic [N*DW-1:0] m_dat_i = '0;
   logic [N-1:0]    m_ack_o, m_err_o, m_stall_o, grant_o;
   logic [DW-1:0]   m_dat_o, s_dat_o;
   logic            s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]   s_adr_o;
   logic [SW-1:0]   s_sel_o;
   logic            s_ack_i = 1'b0, s_err_i = 1'b0, s_stall_i = 1'b0;
   logic [DW-1:0]   s_dat_i = '0;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
   logic            timeout_o;
`endif

   wb_rr_arbiter #(
      .N_MASTERS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW)
`ifdef WB_RR_ARBITER_WATCHDOG_EN
      , .TIMEOUT_CYC (TO)
`endif
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .m_cyc_i   (m_cyc_i),
      .m_stb_i   (m_stb_i),
      .m_we_i    (m_we_i),
      .m_adr_i   (m_adr_i),
      .m_sel_i   (m_sel_i),
      .m_dat_i   (m_dat_i),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .m_stall_o (m_stall_o),
      .m_dat_o   (m_dat_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_we_o    (s_we_o),
      .s_adr_o   (s_adr_o),
      .s_sel_o   (s_sel_o),
      .s_dat_o   (s_dat_o),
      .s_ack_i   (s_ack_i),
      .s_err_i   (s_err_i),
      .s_stall_i (s_stall_i),
      .s_dat_i   (s_dat_i),
      .grant_o   (grant_o)
`ifdef WB_RR_ARBITER_WATCHDOG_EN
      , .timeout_o (timeout_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int unsigned   master;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   ack_cnt[N];

   // Scoreboard: every ack must match the oldest expected {master, read data} entry.
   always @(negedge clk_i) begin
      exp_t         e;
      logic [N-1:0] exp_ack;
      if (!rst_i && m_ack_o != '0) begin
         for (int i = 0; i < N; i++) if (m_ack_o[i]) ack_cnt[i]++;
         n_assert++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_ack: m_ack_o=%b while scoreboard empty", m_ack_o);
         end else begin
            e       = sb_q.pop_front();
            exp_ack = N'(1 << e.master);
            if (m_ack_o !== exp_ack || m_dat_o !== e.data) begin
               n_fail++;
               $display("FAIL sb_ack: m_ack_o=%b m_dat_o=%h, expected %b %h",
                        m_ack_o, m_dat_o, exp_ack, e.data);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid;
      @(negedge clk_i);
   endtask

   task automatic clear_inputs;
      m_cyc_i   = '0;
      m_stb_i   = '0;
      m_we_i    = '0;
      m_adr_i   = '0;
      m_sel_i   = '1;
      m_dat_i   = '0;
      s_ack_i   = 1'b0;
      s_err_i   = 1'b0;
      s_stall_i = 1'b0;
      s_dat_i   = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic set_adr(input int m, input logic [AW-1:0] a);
      m_adr_i[m*AW +: AW] = a;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst_i = 1'b1;
      tick();
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
      n_assert++;
      if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_slave: cyc=%b stb=%b expected 0 0", s_cyc_o, s_stb_o);
      end
      n_assert++;
      if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
         n_fail++; $display("FAIL reset_ack_err: ack=%b err=%b expected 00 00", m_ack_o, m_err_o);
      end
      n_assert++;
      if (m_stall_o !== 2'b11) begin n_fail++; $display("FAIL reset_stall: got %b expected 11", m_stall_o); end
`ifdef WB_RR_ARBITER_WATCHDOG_EN
      n_assert++;
      if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
`endif
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_single_read;
      do_reset();
      m_cyc_i = 2'b01;
      m_stb_i = 2'b01;
      set_adr(0, 8'h04);
      mid();
      n_assert++;
      if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
         n_fail++; $display("FAIL decision_cycle: grant=%b s_cyc=%b expected 00 0", grant_o, s_cyc_o);
      end
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", grant_o); end
      n_assert++;
      if (s_adr_o !== 8'h04 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) begin
         n_fail++; $display("FAIL single_slave: adr=%h cyc=%b stb=%b expected 04 1 1", s_adr_o, s_cyc_o, s_stb_o);
      end
      n_assert++;
      if (m_stall_o !== 2'b10) begin n_fail++; $display("FAIL single_stall: got %b expected 10", m_stall_o); end
      tick();
      m_stb_i = 2'b00;
      s_ack_i = 1'b1;
      s_dat_i = 32'hDEAD_BEEF;
      sb_q.push_back('{master: 0, data: 32'hDEAD_BEEF});
      mid();
      n_assert++;
      if (m_stall_o[1] !== 1'b1) begin n_fail++; $display("FAIL single_stall1: got %b expected 1", m_stall_o[1]); end
      tick();
      s_ack_i = 1'b0;
      s_dat_i = '0;
      m_cyc_i = 2'b00;
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b expected 00", grant_o); end
   endtask

   task automatic test_simultaneous;
      do_reset();
      m_cyc_i = 2'b11;
      m_stb_i = 2'b11;
      set_adr(0, 8'h10);
      set_adr(1, 8'h20);
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b01 || s_adr_o !== 8'h10) begin
         n_fail++; $display("FAIL simul_first: grant=%b adr=%h expected 01 10", grant_o, s_adr_o);
      end
      n_assert++;
      if (m_stall_o !== 2'b10) begin n_fail++; $display("FAIL simul_stall: got %b expected 10", m_stall_o); end
      tick();
      m_stb_i[0] = 1'b0;
      s_ack_i    = 1'b1;
      s_dat_i    = 32'h1234_5678;
      sb_q.push_back('{master: 0, data: 32'h1234_5678});
      tick();
      s_ack_i    = 1'b0;
      m_cyc_i[0] = 1'b0;
      mid();
      n_assert++;
      if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL simul_drop: s_cyc=%b expected 0", s_cyc_o); end
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
         n_fail++; $display("FAIL simul_gap: grant=%b s_cyc=%b expected 00 0", grant_o, s_cyc_o);
      end
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b10 || s_adr_o !== 8'h20 || s_cyc_o !== 1'b1) begin
         n_fail++; $display("FAIL simul_second: grant=%b adr=%h cyc=%b expected 10 20 1", grant_o, s_adr_o, s_cyc_o);
      end
      tick();
      m_stb_i = 2'b00;
      s_ack_i = 1'b1;
      s_dat_i = 32'hCAFE_0001;
      sb_q.push_back('{master: 1, data: 32'hCAFE_0001});
      tick();
      s_ack_i = 1'b0;
      m_cyc_i = 2'b00;
      tick();
      tick();
   endtask

   task automatic test_fairness;
      int            exp_g;
      bit            got;
      logic [DW-1:0] d;
      do_reset();
      m_cyc_i = 2'b11;
      m_stb_i = 2'b11;
      exp_g   = 0;
      for (int it = 0; it < 10; it++) begin
         got = 1'b0;
         for (int c = 0; c < 6; c++) begin
            mid();
            if (grant_o != '0) begin got = 1'b1; break; end
            tick();
         end
         n_assert++;
         if (!got) begin
            n_fail++; $display("FAIL fair_timeout: iteration %0d no grant within 6 cycles", it);
         end else if (grant_o !== N'(1 << exp_g)) begin
            n_fail++; $display("FAIL fair_order: iteration %0d grant=%b expected %b", it, grant_o, N'(1 << exp_g));
         end
         tick();
         d              = $urandom;
         m_stb_i[exp_g] = 1'b0;
         s_ack_i        = 1'b1;
         s_dat_i        = d;
         sb_q.push_back('{master: exp_g, data: d});
         tick();
         s_ack_i        = 1'b0;
         m_cyc_i[exp_g] = 1'b0;
         tick();
         m_cyc_i[exp_g] = 1'b1;
         m_stb_i[exp_g] = 1'b1;
         exp_g          = 1 - exp_g;
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_burst_hold;
      int issued, acks_sent, c;
      bit pend, accept;
      do_reset();
      m_cyc_i = 2'b10;
      m_we_i  = 2'b10;
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b10) begin n_fail++; $display("FAIL burst_grant: got %b expected 10", grant_o); end
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      issued    = 0;
      acks_sent = 0;
      pend      = 1'b0;
      c         = 0;
      while (acks_sent < 4 && c < 20) begin
         tick();
         m_cyc_i[0] = 1'b1;
         m_stb_i[1] = (issued < 4);
         set_adr(1, AW'(8'h30 + issued));
         m_dat_i[DW +: DW] = 32'hA000_0000 + issued;
         s_stall_i = (c < 2);
         s_ack_i   = pend;
         s_dat_i   = 32'h0000_0B00 + acks_sent;
         if (pend) begin
            sb_q.push_back('{master: 1, data: 32'h0000_0B00 + acks_sent});
            acks_sent++;
         end
         mid();
         n_assert++;
         if (grant_o !== 2'b10 || m_stall_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL burst_hold: cycle %0d grant=%b stall0=%b expected 10 1", c, grant_o, m_stall_o[0]);
         end
         if (s_stb_o) begin
            n_assert++;
            if (s_adr_o !== AW'(8'h30 + issued) || s_we_o !== 1'b1) begin
               n_fail++; $display("FAIL burst_adr: adr=%h we=%b expected %h 1", s_adr_o, s_we_o, AW'(8'h30 + issued));
            end
         end
         accept = s_cyc_o && s_stb_o && !s_stall_i;
         if (accept) issued++;
         pend = accept;
         c++;
      end
      n_assert++;
      if (acks_sent != 4) begin n_fail++; $display("FAIL burst_budget: %0d acks sent expected 4", acks_sent); end
      tick();
      s_ack_i    = 1'b0;
      s_stall_i  = 1'b0;
      m_stb_i    = 2'b00;
      m_cyc_i[1] = 1'b0;
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b00) begin n_fail++; $display("FAIL burst_gap: grant=%b expected 00", grant_o); end
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b01) begin n_fail++; $display("FAIL burst_next: grant=%b expected 01", grant_o); end
      n_assert++;
      if (ack_cnt[1] != 4 || ack_cnt[0] != 0) begin
         n_fail++; $display("FAIL burst_acks: m1=%0d m0=%0d expected 4 0", ack_cnt[1], ack_cnt[0]);
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_reset_mid;
      do_reset();
      m_cyc_i = 2'b01;
      m_stb_i = 2'b01;
      tick();
      mid();
      n_assert++;
      if (grant_o !== 2'b01) begin n_fail++; $display("FAIL rstmid_pre: grant=%b expected 01", grant_o); end
      tick();
      rst_i = 1'b1;
      tick();
      s_ack_i = 1'b1;
      mid();
      n_assert++;
      if (s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
         n_fail++; $display("FAIL rstmid_drop: s_cyc=%b grant=%b expected 0 00", s_cyc_o, grant_o);
      end
      n_assert++;
      if (m_stall_o !== 2'b11 || m_ack_o !== 2'b00) begin
         n_fail++; $display("FAIL rstmid_outs: stall=%b ack=%b expected 11 00", m_stall_o, m_ack_o);
      end
      tick();
      s_ack_i = 1'b0;
      clear_inputs();
      tick();
      rst_i = 1'b0;
      tick();
   endtask

`ifdef WB_RR_ARBITER_WATCHDOG_EN
   task automatic test_watchdog;
      int           n, err_n, g1_n, pulses;
      logic [N-1:0] err_val;
      logic         cyc_at_err, to_pre;
      do_reset();
      m_cyc_i    = 2'b11;
      m_stb_i    = 2'b11;
      n          = -1;
      err_n      = -1;
      g1_n       = -1;
      pulses     = 0;
      err_val    = '0;
      cyc_at_err = 1'bx;
      to_pre     = 1'bx;
      for (int c = 0; c < 60; c++) begin
         mid();
         if (n < 0 && grant_o == 2'b01) n = 0;
         else if (n >= 0) n++;
         if (n == 15) to_pre = timeout_o;
         if (m_err_o != '0) begin
            pulses++;
            if (err_n < 0) begin
               err_n      = n;
               err_val    = m_err_o;
               cyc_at_err = s_cyc_o;
            end
         end
         if (grant_o == 2'b10) begin g1_n = n; break; end
         tick();
      end
      n_assert++;
      if (to_pre !== 1'b0) begin n_fail++; $display("FAIL wd_pre: timeout_o=%b expected 0", to_pre); end
      n_assert++;
      if (err_n != TO || err_val !== 2'b01 || cyc_at_err !== 1'b0) begin
         n_fail++; $display("FAIL wd_err: at=%0d err=%b s_cyc=%b expected %0d 01 0", err_n, err_val, cyc_at_err, TO);
      end
      n_assert++;
      if (pulses != 1) begin n_fail++; $display("FAIL wd_pulses: got %0d expected 1", pulses); end
      n_assert++;
      if (g1_n != TO + 2) begin n_fail++; $display("FAIL wd_next: master1 granted at %0d expected %0d", g1_n, TO + 2); end
      clear_inputs();
      tick();
      tick();
      tick();
      mid();
      n_assert++;
      if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: timeout_o=%b expected 1", timeout_o); end
      do_reset();
      mid();
      n_assert++;
      if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL wd_clear: timeout_o=%b expected 0", timeout_o); end
   endtask
`endif

   initial begin
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      test_reset();
      test_single_read();
      test_simultaneous();
      test_fairness();
      test_burst_hold();
      test_reset_mid();
`ifdef WB_RR_ARBITER_WATCHDOG_EN
      test_watchdog();
`endif
      tick();
      n_assert++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL sb_drain: %0d expected acks never seen", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
